// File: rtl/mandelbrot_iter_engine_if.sv
// Start/done handshake and point/result bundle for the Mandelbrot engine.
// master drives a point request, slave returns the escape-time result.
interface mandelbrot_iter_engine_if #(
    parameter int WIDTH  = 16,
    parameter int ITER_W = 8
);
    logic                     start;
    logic signed [WIDTH-1:0]  c_real;
    logic signed [WIDTH-1:0]  c_imag;
    logic [ITER_W-1:0]        max_iter;
    logic                     busy;
    logic                     done;
    logic [ITER_W-1:0]        iter_count;
    logic                     escaped;

    modport master (
        output start, c_real, c_imag, max_iter,
        input  busy, done, iter_count, escaped
    );

    modport slave (
        input  start, c_real, c_imag, max_iter,
        output busy, done, iter_count, escaped
    );
endinterface

// File: rtl/mandelbrot_iter_engine.sv
// Sequential escape-time engine: iterates z <- z^2 + c for one point per
// start/done transaction, stopping on divergence, overflow or the limit.
module mandelbrot_iter_engine #(
    parameter int WIDTH  = 16,
    parameter int FRAC   = 12,
    parameter int ITER_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    mandelbrot_iter_engine_if.slave   bus
);
    localparam int W2 = 2 * WIDTH;
    localparam logic signed [W2-1:0] LIM  = W2'(4) << FRAC;
    localparam logic signed [W2-1:0] MAXV = (W2'(1) << (WIDTH - 1)) - W2'(1);
    localparam logic signed [W2-1:0] MINV = -MAXV - W2'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    state_t                   r_state;
    logic signed [WIDTH-1:0]  r_zr;
    logic signed [WIDTH-1:0]  r_zi;
    logic signed [WIDTH-1:0]  r_cr;
    logic signed [WIDTH-1:0]  r_ci;
    logic [ITER_W-1:0]        r_max;
    logic [ITER_W-1:0]        r_cnt;
    logic                     r_busy;
    logic                     r_done;
    logic [ITER_W-1:0]        r_iter;
    logic                     r_esc;

    logic signed [W2-1:0] w_zr_x, w_zi_x, w_cr_x, w_ci_x;
    logic signed [W2-1:0] w_pr, w_pi, w_pri;
    logic signed [W2-1:0] w_zr2, w_zi2, w_zri;
    logic signed [W2-1:0] w_nr, w_ni, w_mag;
    logic                 w_ovf;
    logic                 w_stop_esc;

    always_comb begin
        w_zr_x = {{WIDTH{r_zr[WIDTH-1]}}, r_zr};
        w_zi_x = {{WIDTH{r_zi[WIDTH-1]}}, r_zi};
        w_cr_x = {{WIDTH{r_cr[WIDTH-1]}}, r_cr};
        w_ci_x = {{WIDTH{r_ci[WIDTH-1]}}, r_ci};
        w_pr   = w_zr_x * w_zr_x;
        w_pi   = w_zi_x * w_zi_x;
        w_pri  = w_zr_x * w_zi_x;
        w_zr2  = w_pr >>> FRAC;
        w_zi2  = w_pi >>> FRAC;
        // one bit less of shift doubles the cross term
        w_zri  = w_pri >>> (FRAC - 1);
        w_nr   = w_zr2 - w_zi2 + w_cr_x;
        w_ni   = w_zri + w_ci_x;
        w_mag  = w_zr2 + w_zi2;
        w_ovf  = (w_nr > MAXV) || (w_nr < MINV) ||
                 (w_ni > MAXV) || (w_ni < MINV);
        w_stop_esc = (w_mag > LIM) || w_ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_zr    <= '0;
            r_zi    <= '0;
            r_cr    <= '0;
            r_ci    <= '0;
            r_max   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_iter  <= '0;
            r_esc   <= 1'b0;
        end else begin
            case (r_state)
                S_ITER: begin
                    if (w_stop_esc) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_iter  <= r_cnt;
                        r_esc   <= 1'b1;
                    end else if (r_cnt == r_max) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_iter  <= r_cnt;
                        r_esc   <= 1'b0;
                    end else begin
                        r_zr  <= w_nr[WIDTH-1:0];
                        r_zi  <= w_ni[WIDTH-1:0];
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= S_ITER;
                        r_busy  <= 1'b1;
                        r_cr    <= bus.c_real;
                        r_ci    <= bus.c_imag;
                        r_max   <= bus.max_iter;
                        r_zr    <= '0;
                        r_zi    <= '0;
                        r_cnt   <= '0;
                        r_iter  <= '0;
                        r_esc   <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.iter_count = r_iter;
    assign bus.escaped    = r_esc;
endmodule

// File: tb/tb_mandelbrot_iter_engine.sv
// Directed and randomized bench for the Mandelbrot engine, FRAC=12 and
// FRAC=13 instances, checked against an integer escape-time model.
module tb_mandelbrot_iter_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mandelbrot_iter_engine_if #(.WIDTH(16), .ITER_W(8)) a ();
    mandelbrot_iter_engine_if #(.WIDTH(16), .ITER_W(8)) b ();

    mandelbrot_iter_engine #(.WIDTH(16), .FRAC(12), .ITER_W(8)) dut12 (
        .clk(clk), .rst(rst), .bus(a.slave)
    );
    mandelbrot_iter_engine #(.WIDTH(16), .FRAC(13), .ITER_W(8)) dut13 (
        .clk(clk), .rst(rst), .bus(b.slave)
    );

    function automatic bit o_busy(input bit sel);
        return sel ? b.busy : a.busy;
    endfunction
    function automatic bit o_done(input bit sel);
        return sel ? b.done : a.done;
    endfunction
    function automatic int o_iter(input bit sel);
        return sel ? int'(b.iter_count) : int'(a.iter_count);
    endfunction
    function automatic bit o_esc(input bit sel);
        return sel ? b.escaped : a.escaped;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Escape-time reference: plain integer arithmetic on the real values
    // scaled by 2^frac, stopping before any unrepresentable z.
    task automatic model(input int frac, input logic signed [15:0] cr,
                         input logic signed [15:0] ci, input int mi,
                         output int cnt, output bit esc);
        longint zr = 0, zi = 0, c_r = cr, c_i = ci;
        longint zr2, zi2, zri, nr, ni;
        cnt = 0;
        esc = 1'b0;
        for (int k = 0; k <= 256; k++) begin
            zr2 = (zr * zr) >>> frac;
            zi2 = (zi * zi) >>> frac;
            zri = (2 * zr * zi) >>> frac;
            nr  = zr2 - zi2 + c_r;
            ni  = zri + c_i;
            if ((zr2 + zi2) > (64'sd4 <<< frac) ||
                nr > 32767 || nr < -32768 || ni > 32767 || ni < -32768) begin
                cnt = k; esc = 1'b1; return;
            end
            if (k == mi) begin
                cnt = k; esc = 1'b0; return;
            end
            zr = nr;
            zi = ni;
        end
    endtask

    // Called with start to be sampled at the next rising edge.
    task automatic launch(input bit sel, input logic signed [15:0] cr,
                          input logic signed [15:0] ci, input int mi);
        a.c_real = cr; a.c_imag = ci; a.max_iter = 8'(mi);
        b.c_real = cr; b.c_imag = ci; b.max_iter = 8'(mi);
        a.start = !sel;
        b.start = sel;
        @(posedge clk); #1;
        a.start = 1'b0;
        b.start = 1'b0;
    endtask

    // lat is the done cycle relative to the start cycle T.
    task automatic wait_done(input bit sel, output int lat, output int nbusy);
        int n = 0;
        nbusy = o_busy(sel) ? 1 : 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (o_busy(sel)) nbusy++;
        end while (!o_done(sel) && n < 600);
        lat = n + 1;
    endtask

    task automatic run(input string tag, input bit sel, input logic signed [15:0] cr,
                       input logic signed [15:0] ci, input int mi,
                       input int e_cnt, input bit e_esc);
        int lat, nb;
        @(negedge clk);
        launch(sel, cr, ci, mi);
        wait_done(sel, lat, nb);
        chk({tag, ".done"}, o_done(sel), 1);
        chk({tag, ".lat"}, lat, e_cnt + 2);
        chk({tag, ".busy"}, nb, e_cnt + 1);
        chk({tag, ".iter"}, o_iter(sel), e_cnt);
        chk({tag, ".esc"}, o_esc(sel), e_esc);
        @(posedge clk); #1;
        chk({tag, ".pulse"}, o_done(sel), 0);
        chk({tag, ".hold"}, o_iter(sel), e_cnt);
    endtask

    initial begin
        int lat, nb, ecnt, ndone;
        bit eesc;
        logic signed [15:0] cr, ci;
        int mi;
        a.start = 0; a.c_real = 0; a.c_imag = 0; a.max_iter = 0;
        b.start = 0; b.c_real = 0; b.c_imag = 0; b.max_iter = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", a.busy, 0);
        chk("rst.done", a.done, 0);
        chk("rst.iter", a.iter_count, 0);
        chk("rst.esc", a.escaped, 0);
        @(negedge clk); rst = 1'b0;

        run("t1", 0, 16'sh0000, 16'sh0000, 20, 20, 0);
        run("t2", 0, 16'sh2000, 16'sh0000, 50, 2, 1);
        run("t3", 0, 16'shF000, 16'sh0000, 255, 255, 0);
        run("t6a", 0, 16'sh7800, 16'sh0000, 10, 1, 1);
        run("t6b", 1, 16'sh3000, 16'sh0000, 10, 2, 1);

        // max_iter=0 then a start in the DONE cycle chains the next point
        @(negedge clk);
        launch(0, 16'sh1234, -16'sh0567, 0);
        wait_done(0, lat, nb);
        chk("t4.lat", lat, 2);
        chk("t4.iter", a.iter_count, 0);
        chk("t4.esc", a.escaped, 0);
        launch(0, 16'sh2000, 16'sh0000, 50);
        chk("t4b.acc", a.busy, 1);
        chk("t4b.clr", a.iter_count, 0);
        wait_done(0, lat, nb);
        chk("t4b.lat", lat, 4);
        chk("t4b.iter", a.iter_count, 2);
        chk("t4b.esc", a.escaped, 1);

        // start while busy must not disturb the point in flight
        @(negedge clk);
        launch(0, 16'sh0000, 16'sh0000, 30);
        repeat (4) @(posedge clk);
        #1;
        launch(0, 16'sh2000, 16'sh0000, 1);
        wait_done(0, lat, nb);
        chk("ign.lat", lat + 5, 32);
        chk("ign.iter", a.iter_count, 30);
        chk("ign.esc", a.escaped, 0);

        // reset mid-point aborts with no done
        @(negedge clk);
        launch(0, 16'sh0000, 16'sh0000, 100);
        repeat (4) @(posedge clk);
        #1;
        launch(0, 16'sh2000, 16'sh0000, 50);
        chk("t5.busy", a.busy, 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5.rbusy", a.busy, 0);
        chk("t5.rdone", a.done, 0);
        chk("t5.riter", a.iter_count, 0);
        chk("t5.resc", a.escaped, 0);
        rst = 1'b0;
        ndone = 0;
        repeat (120) begin
            @(posedge clk); #1;
            if (a.done) ndone++;
        end
        chk("t5.nodone", ndone, 0);

        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                cr = 16'(int'($urandom_range(0, 14335)) - 10240);
                ci = 16'(int'($urandom_range(0, 10239)) - 5120);
            end else begin
                cr = 16'($urandom);
                ci = 16'($urandom);
            end
            mi = int'($urandom_range(0, 80));
            model(12, cr, ci, mi, ecnt, eesc);
            run($sformatf("r12_%0d", i), 0, cr, ci, mi, ecnt, eesc);
        end
        for (int i = 0; i < 12; i++) begin
            cr = 16'(int'($urandom_range(0, 28671)) - 20480);
            ci = 16'(int'($urandom_range(0, 20479)) - 10240);
            mi = int'($urandom_range(0, 60));
            model(13, cr, ci, mi, ecnt, eesc);
            run($sformatf("r13_%0d", i), 1, cr, ci, mi, ecnt, eesc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
